// File: rtl/mem_l1_refill_arbiter_pkg.sv
// Shared types and message-width helpers for the L1 refill arbiter and its tracker.
// Message widths follow the vc mem message layout: type, opaque, addr/test, len, data.
package mem_l1_refill_arbiter_pkg;

  typedef enum logic {
    PORT_ICACHE = 1'b0,
    PORT_DCACHE = 1'b1
  } port_id_t;

  typedef struct packed {
    port_id_t id;
    logic     dom;
  } tracker_entry_t;

  localparam int TRACKER_ENTRY_NBITS = $bits(tracker_entry_t);

  function automatic int mem_req_msg_nbits(input int o, input int a, input int d);
    return 3 + o + a + $clog2(d / 8) + d;
  endfunction

  function automatic int mem_resp_msg_nbits(input int o, input int d);
    return 3 + o + 2 + $clog2(d / 8) + d;
  endfunction

endpackage

// File: rtl/mem_req_tracker_queue.sv
// In-order tracker of outstanding refills: a plain FIFO, no bypass in either direction.
// Depth must be a power of two so the pointers wrap by natural overflow.
module mem_req_tracker_queue
  import mem_l1_refill_arbiter_pkg::*;
#(
  parameter int p_num_entries = 4,
  parameter int p_nbits       = TRACKER_ENTRY_NBITS
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enq_val,
  output logic                           enq_rdy,
  input  logic [p_nbits-1:0]             enq_msg,
  output logic                           deq_val,
  input  logic                           deq_rdy,
  output logic [p_nbits-1:0]             deq_msg,
  output logic [$clog2(p_num_entries):0] count
);

  localparam int c_ptr_nbits = $clog2(p_num_entries);
  localparam logic [c_ptr_nbits:0] c_full = (c_ptr_nbits + 1)'(p_num_entries);

  logic [p_nbits-1:0]     entries [p_num_entries];
  logic [c_ptr_nbits-1:0] enq_ptr_reg;
  logic [c_ptr_nbits-1:0] deq_ptr_reg;
  logic [c_ptr_nbits:0]   count_reg;
  logic                   enq_fire;
  logic                   deq_fire;

  assign enq_rdy  = (count_reg != c_full);
  assign deq_val  = (count_reg != '0);
  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;
  assign deq_msg  = entries[deq_ptr_reg];
  assign count    = count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enq_ptr_reg <= '0;
      deq_ptr_reg <= '0;
      count_reg   <= '0;
    end else begin
      if (enq_fire) enq_ptr_reg <= enq_ptr_reg + c_ptr_nbits'(1);
      if (deq_fire) deq_ptr_reg <= deq_ptr_reg + c_ptr_nbits'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_reg <= count_reg + (c_ptr_nbits + 1)'(1);
        2'b01:   count_reg <= count_reg - (c_ptr_nbits + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (enq_fire) entries[enq_ptr_reg] <= enq_msg;
  end

endmodule

// File: rtl/mem_l1_refill_arbiter.sv
// Round-robin merge of icache/dcache refill requests onto one memory port, with
// in-order steering of responses back to the issuing cache and its security domain.
module mem_l1_refill_arbiter
  import mem_l1_refill_arbiter_pkg::*;
#(
  parameter int p_opaque_nbits    = 8,
  parameter int p_addr_nbits      = 32,
  parameter int p_data_nbits      = 128,
  parameter int p_max_outstanding = 4
) (
  input  logic clk,
  input  logic reset,

  input  logic req0_val,
  output logic req0_rdy,
  input  logic [mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] req0_msg,
  input  logic req0_domain,

  input  logic req1_val,
  output logic req1_rdy,
  input  logic [mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] req1_msg,
  input  logic req1_domain,

  output logic memreq_val,
  input  logic memreq_rdy,
  output logic [mem_req_msg_nbits(p_opaque_nbits, p_addr_nbits, p_data_nbits)-1:0] memreq_msg,
  output logic memreq_domain,

  input  logic memresp_val,
  output logic memresp_rdy,
  input  logic [mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits)-1:0] memresp_msg,

  output logic resp0_val,
  input  logic resp0_rdy,
  output logic [mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits)-1:0] resp0_msg,
  output logic resp0_domain,

  output logic resp1_val,
  input  logic resp1_rdy,
  output logic [mem_resp_msg_nbits(p_opaque_nbits, p_data_nbits)-1:0] resp1_msg,
  output logic resp1_domain,

  output logic protocol_err
);

  localparam int c_cnt_nbits = $clog2(p_max_outstanding) + 1;

  port_id_t             prio_reg;
  port_id_t             winner;
  logic                 protocol_err_reg;
  logic                 not_full;
  logic                 push;
  logic                 pop;
  logic                 head_rdy;
  tracker_entry_t       enq_entry;
  tracker_entry_t       head_entry;
  logic                 tracker_enq_rdy;
  logic                 tracker_deq_val;
  logic [c_cnt_nbits-1:0] tracker_count;

  // Ties go to the pointer; a lone requester wins regardless of it.
  always_comb begin
    winner = prio_reg;
    if (req0_val && !req1_val)      winner = PORT_ICACHE;
    else if (req1_val && !req0_val) winner = PORT_DCACHE;
  end

  assign not_full      = tracker_enq_rdy;
  assign memreq_val    = reset & (req0_val | req1_val) & not_full;
  assign memreq_msg    = (winner == PORT_DCACHE) ? req1_msg : req0_msg;
  assign memreq_domain = (winner == PORT_DCACHE) ? req1_domain : req0_domain;
  assign req0_rdy      = reset & memreq_rdy & not_full & (winner == PORT_ICACHE);
  assign req1_rdy      = reset & memreq_rdy & not_full & (winner == PORT_DCACHE);
  assign push          = memreq_val & memreq_rdy;

  assign enq_entry.id  = winner;
  assign enq_entry.dom = memreq_domain;

  assign head_rdy     = (head_entry.id == PORT_DCACHE) ? resp1_rdy : resp0_rdy;
  assign memresp_rdy  = reset & tracker_deq_val & head_rdy;
  assign resp0_val    = reset & memresp_val & tracker_deq_val & (head_entry.id == PORT_ICACHE);
  assign resp1_val    = reset & memresp_val & tracker_deq_val & (head_entry.id == PORT_DCACHE);
  assign resp0_msg    = memresp_msg;
  assign resp1_msg    = memresp_msg;
  assign resp0_domain = head_entry.dom;
  assign resp1_domain = head_entry.dom;
  assign pop          = memresp_val & memresp_rdy;
  assign protocol_err = protocol_err_reg;

  mem_req_tracker_queue #(
    .p_num_entries (p_max_outstanding),
    .p_nbits       (TRACKER_ENTRY_NBITS)
  ) tracker (
    .clk     (clk),
    .reset   (reset),
    .enq_val (push),
    .enq_rdy (tracker_enq_rdy),
    .enq_msg (enq_entry),
    .deq_val (tracker_deq_val),
    .deq_rdy (pop),
    .deq_msg (head_entry),
    .count   (tracker_count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio_reg         <= PORT_ICACHE;
      protocol_err_reg <= 1'b0;
    end else begin
      if (push) prio_reg <= (winner == PORT_ICACHE) ? PORT_DCACHE : PORT_ICACHE;
      // A response with nothing outstanding means memory has broken ordering.
      if (memresp_val && (tracker_count == '0)) protocol_err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_l1_refill_arbiter.sv
// Scoreboard bench: driver feeds per-port request queues and a memory model; a negedge
// monitor predicts grants/steering from round-robin rules and in-order queues.
module tb_mem_l1_refill_arbiter;
  import mem_l1_refill_arbiter_pkg::*;

  localparam int O = 8, A = 32, D = 128, N = 4;
  localparam int REQ_W    = mem_req_msg_nbits(O, A, D);
  localparam int RESP_W   = mem_resp_msg_nbits(O, D);
  localparam int ADDR_LSB = D + $clog2(D / 8);

  logic clk, reset;
  logic req0_val, req0_rdy, req0_domain, req1_val, req1_rdy, req1_domain;
  logic [REQ_W-1:0] req0_msg, req1_msg, memreq_msg;
  logic memreq_val, memreq_rdy, memreq_domain;
  logic memresp_val, memresp_rdy;
  logic [RESP_W-1:0] memresp_msg, resp0_msg, resp1_msg;
  logic resp0_val, resp0_rdy, resp0_domain, resp1_val, resp1_rdy, resp1_domain;
  logic protocol_err;

  mem_l1_refill_arbiter #(
    .p_opaque_nbits(O), .p_addr_nbits(A), .p_data_nbits(D), .p_max_outstanding(N)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_val(req0_val), .req0_rdy(req0_rdy), .req0_msg(req0_msg), .req0_domain(req0_domain),
    .req1_val(req1_val), .req1_rdy(req1_rdy), .req1_msg(req1_msg), .req1_domain(req1_domain),
    .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_msg(memreq_msg),
    .memreq_domain(memreq_domain),
    .memresp_val(memresp_val), .memresp_rdy(memresp_rdy), .memresp_msg(memresp_msg),
    .resp0_val(resp0_val), .resp0_rdy(resp0_rdy), .resp0_msg(resp0_msg), .resp0_domain(resp0_domain),
    .resp1_val(resp1_val), .resp1_rdy(resp1_rdy), .resp1_msg(resp1_msg), .resp1_domain(resp1_domain),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed { logic [REQ_W-1:0] msg; logic dom; } src_t;
  typedef struct packed { logic port; logic dom; } exp_t;

  src_t              src0_q[$];
  src_t              src1_q[$];
  exp_t              exp_q[$];
  logic [RESP_W-1:0] mem_q[$];
  int                grant_log[$];

  int   checks = 0;
  int   failures = 0;
  bit   en0, en1, mrdy, resp_en, rrdy0, rrdy1, stray, rand_mode;
  logic tie, exp_perr;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [REQ_W-1:0] rand_req();
    logic [REQ_W-1:0] r;
    for (int i = 0; i < REQ_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic logic [RESP_W-1:0] rand_resp();
    logic [RESP_W-1:0] r;
    for (int i = 0; i < RESP_W; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic add_req(input int port, input bit use_addr, input logic [31:0] addr, input logic dom);
    src_t s;
    s.msg = rand_req();
    if (use_addr) s.msg[ADDR_LSB +: 32] = addr;
    s.dom = dom;
    if (port == 0) src0_q.push_back(s); else src1_q.push_back(s);
  endtask

  // ---------------- monitor / reference model ----------------
  logic full, win, grant, hp, hrdy, rfire;
  src_t head;

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_req0_rdy", req0_rdy, 0);
      chk("rst_req1_rdy", req1_rdy, 0);
      chk("rst_memresp_rdy", memresp_rdy, 0);
      chk("rst_resp0_val", resp0_val, 0);
      chk("rst_resp1_val", resp1_val, 0);
      chk("rst_protocol_err", protocol_err, 0);
      exp_q.delete(); mem_q.delete(); tie = 1'b0; exp_perr = 1'b0;
    end else begin
      full  = (exp_q.size() >= N);
      win   = (req0_val && !req1_val) ? 1'b0 : (req1_val && !req0_val) ? 1'b1 : tie;
      grant = (req0_val || req1_val) && !full;
      chk("memreq_val", memreq_val, grant);
      chk("req0_rdy", req0_rdy, memreq_rdy && !full && !win);
      chk("req1_rdy", req1_rdy, memreq_rdy && !full && win);
      if (grant) begin
        head = win ? src1_q[0] : src0_q[0];
        chk("memreq_msg", memreq_msg, head.msg);
        chk("memreq_domain", memreq_domain, head.dom);
      end
      chk("protocol_err", protocol_err, exp_perr);
      rfire = 1'b0;
      if (exp_q.size() > 0) begin
        hp   = exp_q[0].port;
        hrdy = hp ? resp1_rdy : resp0_rdy;
        chk("memresp_rdy", memresp_rdy, hrdy);
        chk("resp0_val", resp0_val, memresp_val && !hp);
        chk("resp1_val", resp1_val, memresp_val && hp);
        if (memresp_val) begin
          chk("resp0_msg", resp0_msg, memresp_msg);
          chk("resp1_msg", resp1_msg, memresp_msg);
          chk("resp_domain", hp ? resp1_domain : resp0_domain, exp_q[0].dom);
        end
        rfire = memresp_val && hrdy;
      end else begin
        chk("empty_memresp_rdy", memresp_rdy, 0);
        chk("empty_resp0_val", resp0_val, 0);
        chk("empty_resp1_val", resp1_val, 0);
        if (memresp_val) exp_perr = 1'b1;
      end
      if (rfire) begin
        void'(exp_q.pop_front());
        void'(mem_q.pop_front());
      end
      if (grant && memreq_rdy) begin
        exp_q.push_back('{port: win, dom: head.dom});
        mem_q.push_back(rand_resp());
        grant_log.push_back(int'(win));
        if (win) void'(src1_q.pop_front()); else void'(src0_q.pop_front());
        tie = ~win;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic drive();
    if (rand_mode) begin
      en0 = ($urandom_range(0, 3) != 0); en1 = ($urandom_range(0, 3) != 0);
      mrdy = ($urandom_range(0, 3) != 0); resp_en = ($urandom_range(0, 2) != 0);
      rrdy0 = ($urandom_range(0, 3) != 0); rrdy1 = ($urandom_range(0, 3) != 0);
    end
    req0_val    = en0 && (src0_q.size() > 0);
    req0_msg    = (src0_q.size() > 0) ? src0_q[0].msg : '0;
    req0_domain = (src0_q.size() > 0) ? src0_q[0].dom : 1'b0;
    req1_val    = en1 && (src1_q.size() > 0);
    req1_msg    = (src1_q.size() > 0) ? src1_q[0].msg : '0;
    req1_domain = (src1_q.size() > 0) ? src1_q[0].dom : 1'b0;
    memreq_rdy  = mrdy;
    memresp_val = stray || (resp_en && (mem_q.size() > 0));
    memresp_msg = stray ? rand_resp() : ((mem_q.size() > 0) ? mem_q[0] : '0);
    resp0_rdy   = rrdy0;
    resp1_rdy   = rrdy1;
  endtask

  task automatic cyc();
    @(posedge clk); #1; drive();
    @(negedge clk); #1;
  endtask

  initial begin
    reset = 1'b0;
    {en0, en1, mrdy, resp_en, rrdy0, rrdy1, stray, rand_mode} = '0;
    req0_val = 1'b1; req1_val = 1'b1; req0_msg = rand_req(); req1_msg = rand_req();
    req0_domain = 1'b1; req1_domain = 1'b0;
    memreq_rdy = 1'b1; memresp_val = 1'b1; memresp_msg = rand_resp();
    resp0_rdy = 1'b1; resp1_rdy = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1; reset = 1'b1; drive();

    // Idle after reset
    repeat (10) cyc();
    chk("idle_memreq_val", memreq_val, 0);
    chk("idle_memresp_rdy", memresp_rdy, 0);
    chk("idle_protocol_err", protocol_err, 0);

    // Both ports busy, memory answers every cycle: strict alternation from port 0
    for (int i = 0; i < 4; i++) begin
      add_req(0, 1, 32'h100, 1'b0);
      add_req(1, 1, 32'h200, 1'b1);
    end
    {en0, en1, mrdy, resp_en, rrdy0, rrdy1} = 6'b111111;
    grant_log.delete();
    repeat (12) cyc();
    chk("alt_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size(); i++) chk("alt_grant_order", grant_log[i], i % 2);

    // Port 1 alone: every grant to port 1, pointer ends at 0
    en0 = 1'b0;
    for (int i = 0; i < 5; i++) add_req(1, 1, 32'h300 + 32'(i * 16), 1'($urandom_range(0, 1)));
    grant_log.delete();
    repeat (10) cyc();
    chk("p1_grant_count", grant_log.size(), 5);
    for (int i = 0; i < grant_log.size(); i++) chk("p1_grant_port", grant_log[i], 1);
    en0 = 1'b1;
    add_req(0, 0, 32'h0, 1'b0);
    add_req(1, 0, 32'h0, 1'b1);
    grant_log.delete();
    repeat (6) cyc();
    chk("prio_grant_count", grant_log.size(), 2);
    if (grant_log.size() > 0) chk("prio_first_after_p1", grant_log[0], 0);

    // Memory stalls: four outstanding fill the tracker, no same-cycle bypass
    en1 = 1'b0; resp_en = 1'b0;
    for (int i = 0; i < 5; i++) add_req(0, 1, 32'h400 + 32'(i * 16), 1'b0);
    grant_log.delete();
    for (int k = 0; k < 20 && grant_log.size() < 4; k++) cyc();
    chk("stall_grants", grant_log.size(), 4);
    cyc();
    chk("full_req0_rdy", req0_rdy, 0);
    resp_en = 1'b1;
    cyc();
    chk("stall_resp0_val", resp0_val, 1);
    chk("no_bypass_req0_rdy", req0_rdy, 0);
    resp_en = 1'b0;
    cyc();
    chk("freed_req0_rdy", req0_rdy, 1);
    resp_en = 1'b1; en1 = 1'b1;
    add_req(1, 0, 32'h0, 1'b0);
    repeat (14) cyc();

    // Grants 0,1,0 then port 1 back-pressures its response
    resp_en = 1'b0;
    add_req(0, 0, 32'h0, 1'b0);
    add_req(1, 0, 32'h0, 1'b1);
    add_req(0, 0, 32'h0, 1'b0);
    grant_log.delete();
    for (int k = 0; k < 20 && grant_log.size() < 3; k++) cyc();
    chk("ilv_grant_count", grant_log.size(), 3);
    for (int i = 0; i < grant_log.size(); i++) chk("ilv_grant_order", grant_log[i], i % 2);
    resp_en = 1'b1; rrdy1 = 1'b0;
    cyc();
    chk("ilv_resp0_val", resp0_val, 1);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("ilv_resp1_val", resp1_val, 1);
      chk("ilv_memresp_rdy_held", memresp_rdy, 0);
      chk("ilv_resp1_domain", resp1_domain, 1);
    end
    rrdy1 = 1'b1;
    cyc();
    chk("ilv_memresp_rdy_rise", memresp_rdy, 1);
    repeat (6) cyc();

    // Randomised traffic
    rand_mode = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (src0_q.size() < 6 && $urandom_range(0, 2) == 0) add_req(0, 0, 32'h0, 1'($urandom_range(0, 1)));
      if (src1_q.size() < 6 && $urandom_range(0, 2) == 0) add_req(1, 0, 32'h0, 1'($urandom_range(0, 1)));
      cyc();
    end
    rand_mode = 1'b0;
    {en0, en1, mrdy, resp_en, rrdy0, rrdy1} = 6'b111111;
    for (int k = 0; k < 200 && (exp_q.size() > 0 || src0_q.size() > 0 || src1_q.size() > 0); k++) cyc();
    chk("drain_outstanding", exp_q.size(), 0);

    // Stray response with empty tracker
    stray = 1'b1;
    cyc();
    chk("stray_memresp_rdy", memresp_rdy, 0);
    chk("stray_err_not_yet", protocol_err, 0);
    stray = 1'b0;
    cyc();
    chk("stray_err_set", protocol_err, 1);
    cyc();
    chk("stray_err_sticky", protocol_err, 1);

    // Asynchronous reset mid-cycle with a request pending
    mrdy = 1'b0;
    add_req(0, 0, 32'h0, 1'b0);
    cyc();
    chk("pending_memreq_val", memreq_val, 1);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_rst_protocol_err", protocol_err, 0);
    chk("async_rst_memreq_val", memreq_val, 0);
    repeat (2) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
